wb_queue: RTL and testbench

- Producer side of the register-file write port: generates wr_en/wr_idx/wr_data for the 32x32 register file.
- Merges two result sources onto the single write port:
  - single-cycle ALU path: non-stallable, highest priority.
  - long-latency path (mul/div/load): valid/ready handshake, buffered in a DEPTH-entry FIFO.
- Exports a pending-write mask so issue logic can stall on RAW/WAW against queued results.

---
 rtl/wb_queue.sv | 134 +++++++++++++
 tb/tb_wb_queue.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// Register-file write-port producer: merges the ALU result path with a FIFO of long-latency results.
// Optional feature macro WBQ_BYPASS_EN: an empty FIFO with an idle ALU writes an offered result directly.
module wb_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid_i,
    input  logic [4:0]               alu_idx_i,
    input  logic [DATA_W-1:0]        alu_data_i,
    input  logic                     lu_valid_i,
    output logic                     lu_ready_o,
    input  logic [4:0]               lu_idx_i,
    input  logic [DATA_W-1:0]        lu_data_i,
    output logic                     wr_en_o,
    output logic [4:0]               wr_idx_o,
    output logic [DATA_W-1:0]        wr_data_o,
    output logic [31:0]              pending_mask_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [4:0]        idx_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic alu_wr, fifo_ne, full, bypass, push, pop;

    assign alu_wr     = alu_valid_i && (alu_idx_i != 5'd0);
    assign fifo_ne    = (count_q != '0);
    assign full       = (count_q == CntW'(DEPTH));
    assign lu_ready_o = rst_n && !full;

`ifdef WBQ_BYPASS_EN
    assign bypass = !fifo_ne && !alu_wr && lu_valid_i && (lu_idx_i != 5'd0);
`else
    assign bypass = 1'b0;
`endif

    // Index-0 results complete the handshake but are dropped here.
    assign push = lu_valid_i && lu_ready_o && (lu_idx_i != 5'd0) && !bypass;
    assign pop  = rst_n && !alu_wr && fifo_ne;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        vld_d    = vld_q;
        if (pop) begin
            rd_ptr_d        = rd_ptr_q + 1'b1;
            vld_d[rd_ptr_q] = 1'b0;
        end
        if (push) begin
            wr_ptr_d        = wr_ptr_q + 1'b1;
            vld_d[wr_ptr_q] = 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            vld_q    <= vld_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by vld_q.
    always_ff @(posedge clk) begin
        if (push) begin
            idx_q[wr_ptr_q]  <= lu_idx_i;
            data_q[wr_ptr_q] <= lu_data_i;
        end
    end

    always_comb begin
        pending_mask_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[i]) begin
                pending_mask_o[idx_q[i]] = 1'b1;
            end
        end
    end

    always_comb begin
        wr_en_o   = 1'b0;
        wr_idx_o  = '0;
        wr_data_o = '0;
        if (!rst_n) begin
            wr_en_o = 1'b0;
        end else if (alu_wr) begin
            wr_en_o   = 1'b1;
            wr_idx_o  = alu_idx_i;
            wr_data_o = alu_data_i;
        end else if (fifo_ne) begin
            wr_en_o   = 1'b1;
            wr_idx_o  = idx_q[rd_ptr_q];
            wr_data_o = data_q[rd_ptr_q];
        end else if (bypass) begin
            wr_en_o   = 1'b1;
            wr_idx_o  = lu_idx_i;
            wr_data_o = lu_data_i;
        end
    end

    assign count_o = count_q;

`ifndef SYNTHESIS
    // Issue must stall on pending registers, so an ALU write to one is a hazard upstream.
    always_ff @(posedge clk) begin
        if (rst_n && alu_wr) begin
            assert (!pending_mask_o[alu_idx_i])
            else $error("wb_queue: ALU write to pending register %0d", alu_idx_i);
        end
    end
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue (expects DEPTH=4, DATA_W=32).
module tb_wb_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_idx;
    logic [31:0] alu_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_idx;
    logic [31:0] lu_data;
    logic        wr_en;
    logic [4:0]  wr_idx;
    logic [31:0] wr_data;
    logic [31:0] pending_mask;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_queue #(.DEPTH(4), .DATA_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_valid_i    (alu_valid),
        .alu_idx_i      (alu_idx),
        .alu_data_i     (alu_data),
        .lu_valid_i     (lu_valid),
        .lu_ready_o     (lu_ready),
        .lu_idx_i       (lu_idx),
        .lu_data_i      (lu_data),
        .wr_en_o        (wr_en),
        .wr_idx_o       (wr_idx),
        .wr_data_o      (wr_data),
        .pending_mask_o (pending_mask),
        .count_o        (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Inputs change just after a falling edge; outputs are sampled 1 time unit later.
    task automatic cyc(input logic av, input logic [4:0] ai, input logic [31:0] ad,
                       input logic lv, input logic [4:0] li, input logic [31:0] ld);
        @(negedge clk);
        alu_valid = av;
        alu_idx   = ai;
        alu_data  = ad;
        lu_valid  = lv;
        lu_idx    = li;
        lu_data   = ld;
        #1;
    endtask

    logic [4:0] wl [10];
    logic [4:0] e_idx;
    logic [31:0] e_data;
    int e_cnt;

    initial begin
        wl = '{5'd2, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10};
        rst_n = 1'b1;
        alu_valid = 1'b1; alu_idx = 5'd5; alu_data = 32'h55;
        lu_valid = 1'b0; lu_idx = 5'd0; lu_data = 32'h0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_pending", pending_mask, 32'd0);
        chk("rst_lu_ready", 32'(lu_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_wr_en", 32'(wr_en), 32'd1);
        chk("rel_wr_idx", 32'(wr_idx), 32'd5);
        chk("rel_wr_data", wr_data, 32'h55);

        // Priority: queued result waits behind ALU writes.
        cyc(1'b1, 5'd1, 32'h1, 1'b1, 5'd3, 32'hAAAA0003);
        chk("pri0_wr_idx", 32'(wr_idx), 32'd1);
        chk("pri0_lu_ready", 32'(lu_ready), 32'd1);
        cyc(1'b1, 5'd7, 32'h7, 1'b0, 5'd0, 32'h0);
        chk("pri1_wr_idx", 32'(wr_idx), 32'd7);
        chk("pri1_count", 32'(count), 32'd1);
        chk("pri1_pending", pending_mask, 32'h8);
        cyc(1'b1, 5'd8, 32'h8, 1'b0, 5'd0, 32'h0);
        chk("pri2_wr_idx", 32'(wr_idx), 32'd8);
        chk("pri2_pending", pending_mask, 32'h8);
        cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("pri3_wr_en", 32'(wr_en), 32'd1);
        chk("pri3_wr_idx", 32'(wr_idx), 32'd3);
        chk("pri3_wr_data", wr_data, 32'hAAAA0003);
        cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("pri4_wr_en", 32'(wr_en), 32'd0);
        chk("pri4_wr_idx", 32'(wr_idx), 32'd0);
        chk("pri4_wr_data", wr_data, 32'd0);
        chk("pri4_pending", pending_mask, 32'd0);

        // Full and backpressure.
        cyc(1'b1, 5'd1, 32'h11, 1'b1, 5'd4, 32'h44);
        cyc(1'b1, 5'd1, 32'h11, 1'b1, 5'd5, 32'h55);
        cyc(1'b1, 5'd1, 32'h11, 1'b1, 5'd6, 32'h66);
        cyc(1'b1, 5'd1, 32'h11, 1'b1, 5'd7, 32'h77);
        cyc(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h99);
        chk("full_count", 32'(count), 32'd4);
        chk("full_lu_ready", 32'(lu_ready), 32'd0);
        chk("full_pending", pending_mask, 32'h0F0);
        chk("full_wr_idx", 32'(wr_idx), 32'd1);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
        chk("bp0_wr_idx", 32'(wr_idx), 32'd4);
        chk("bp0_wr_data", wr_data, 32'h44);
        chk("bp0_lu_ready", 32'(lu_ready), 32'd0);
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
        chk("bp1_wr_idx", 32'(wr_idx), 32'd5);
        chk("bp1_lu_ready", 32'(lu_ready), 32'd1);
        chk("bp1_count", 32'(count), 32'd3);
        cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("bp2_wr_idx", 32'(wr_idx), 32'd6);
        chk("bp2_count", 32'(count), 32'd3);
        chk("bp2_pending", pending_mask, 32'h2C0);
        cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("bp3_wr_idx", 32'(wr_idx), 32'd7);
        cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("bp4_wr_idx", 32'(wr_idx), 32'd9);
        chk("bp4_wr_data", wr_data, 32'h99);
        chk("bp4_count", 32'(count), 32'd1);
        cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("bp5_wr_en", 32'(wr_en), 32'd0);
        chk("bp5_count", 32'(count), 32'd0);

        // Register 0 filtering.
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD);
        chk("z0_lu_ready", 32'(lu_ready), 32'd1);
        chk("z0_wr_en", 32'(wr_en), 32'd0);
        cyc(1'b1, 5'd0, 32'hBEEF, 1'b0, 5'd0, 32'h0);
        chk("z1_count", 32'(count), 32'd0);
        chk("z1_wr_en", 32'(wr_en), 32'd0);
        chk("z1_wr_idx", 32'(wr_idx), 32'd0);
        chk("z1_pending", pending_mask, 32'd0);

        // Streaming with wrap and duplicate indices; two entries stay in flight.
        for (int k = 0; k < 12; k++) begin
            cyc(k < 2, 5'd1, 32'h1, k < 10, (k < 10) ? wl[k] : 5'd0,
                (k < 10) ? (32'hC0DE0000 | (32'(k) << 8) | 32'(wl[k])) : 32'h0);
            e_cnt  = (k == 0) ? 0 : (k == 1) ? 1 : (k <= 10) ? 2 : 1;
            e_idx  = (k < 2) ? 5'd1 : wl[k-2];
            e_data = (k < 2) ? 32'h1 : (32'hC0DE0000 | (32'(k - 2) << 8) | 32'(wl[k-2]));
            chk($sformatf("wrap%0d_count", k), 32'(count), 32'(e_cnt));
            chk($sformatf("wrap%0d_wr_idx", k), 32'(wr_idx), 32'(e_idx));
            chk($sformatf("wrap%0d_wr_data", k), wr_data, e_data);
            if (k == 2) chk("wrap2_pending", pending_mask, 32'h4);
            if (k == 3) chk("wrap3_pending", pending_mask, 32'hC);
            if (k == 4) chk("wrap4_pending", pending_mask, 32'h18);
        end
        cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("wrap_end_count", 32'(count), 32'd0);
        chk("wrap_end_wr_en", 32'(wr_en), 32'd0);

        // Empty FIFO, idle ALU: direct write with the bypass, one-cycle delay without it.
        cyc(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h1234);
        chk("byp0_lu_ready", 32'(lu_ready), 32'd1);
`ifdef WBQ_BYPASS_EN
        chk("byp0_wr_en", 32'(wr_en), 32'd1);
        chk("byp0_wr_idx", 32'(wr_idx), 32'd12);
        chk("byp0_wr_data", wr_data, 32'h1234);
        cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("byp1_count", 32'(count), 32'd0);
        chk("byp1_pending", pending_mask, 32'd0);
        chk("byp1_wr_en", 32'(wr_en), 32'd0);
`else
        chk("byp0_wr_en", 32'(wr_en), 32'd0);
        cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("byp1_count", 32'(count), 32'd1);
        chk("byp1_pending", pending_mask, 32'h1000);
        chk("byp1_wr_en", 32'(wr_en), 32'd1);
        chk("byp1_wr_idx", 32'(wr_idx), 32'd12);
        chk("byp1_wr_data", wr_data, 32'h1234);
`endif
        cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("byp2_count", 32'(count), 32'd0);
        chk("byp2_wr_en", 32'(wr_en), 32'd0);

        // Reset while entries are queued drops them.
        cyc(1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'h20);
        cyc(1'b1, 5'd1, 32'h1, 1'b1, 5'd21, 32'h21);
        @(negedge clk);
        rst_n = 1'b0;
        alu_valid = 1'b1; alu_idx = 5'd3;
        lu_valid = 1'b0;
        #1;
        chk("mrst_count", 32'(count), 32'd0);
        chk("mrst_pending", pending_mask, 32'd0);
        chk("mrst_wr_en", 32'(wr_en), 32'd0);
        chk("mrst_lu_ready", 32'(lu_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("mrst_rel_count", 32'(count), 32'd0);
        chk("mrst_rel_wr_en", 32'(wr_en), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
